// File: rtl/mul_fu_ctrl.sv
// Multiply functional-unit controller: takes one RV32M multiply op from the RS,
// drives a start/done multiplier, selects the product half and returns it on the CDB.
module mul_fu_ctrl #(
  parameter int ROB_IDX_W = 5,
  parameter int XLEN      = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush_i,
  input  logic                 issue_valid_i,
  output logic                 issue_ready_o,
  input  logic [2:0]           issue_funct3_i,
  input  logic [XLEN-1:0]      issue_rs1_v_i,
  input  logic [XLEN-1:0]      issue_rs2_v_i,
  input  logic [ROB_IDX_W-1:0] issue_rob_tag_i,
  input  logic [4:0]           issue_rd_i,
  output logic                 mul_start_o,
  output logic [1:0]           mul_type_o,
  output logic [XLEN-1:0]      mul_a_o,
  output logic [XLEN-1:0]      mul_b_o,
  input  logic [2*XLEN-1:0]    mul_p_i,
  input  logic                 mul_done_i,
  output logic                 cdb_valid_o,
  input  logic                 cdb_ready_i,
  output logic [ROB_IDX_W-1:0] cdb_rob_tag_o,
  output logic [4:0]           cdb_rd_o,
  output logic [XLEN-1:0]      cdb_value_o
);

  // state | meaning
  // IDLE  | waiting for an op from the RS
  // BUSY  | mul_start held, waiting for mul_done
  // DRAIN | squashed op finished, one quiet cycle before IDLE
  // RESP  | result on the CDB until accepted or flushed
  typedef enum logic [1:0] {IDLE, BUSY, DRAIN, RESP} state_t;

  state_t                 state_q;
  logic                   squash_q;
  logic [2:0]             funct3_q;
  logic                   mul_start_q;
  logic [1:0]             mul_type_q;
  logic [XLEN-1:0]        mul_a_q;
  logic [XLEN-1:0]        mul_b_q;
  logic                   cdb_valid_q;
  logic [ROB_IDX_W-1:0]   cdb_rob_tag_q;
  logic [4:0]             cdb_rd_q;
  logic [XLEN-1:0]        cdb_value_q;

  logic [1:0]             type_d;
  logic                   fast_zero_d;

  always_comb begin
    type_d = 2'b00;
    case (issue_funct3_i)
      3'b001:  type_d = 2'b01;
      3'b010:  type_d = 2'b10;
      default: type_d = 2'b00;
    endcase
    // Zero operands and illegal funct3 both complete with 0 without the multiplier.
    fast_zero_d = (issue_rs1_v_i == '0) || (issue_rs2_v_i == '0) || issue_funct3_i[2];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      squash_q      <= 1'b0;
      funct3_q      <= '0;
      mul_start_q   <= 1'b0;
      mul_type_q    <= '0;
      mul_a_q       <= '0;
      mul_b_q       <= '0;
      cdb_valid_q   <= 1'b0;
      cdb_rob_tag_q <= '0;
      cdb_rd_q      <= '0;
      cdb_value_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          squash_q <= 1'b0;
          if (issue_valid_i && !flush_i) begin
            cdb_rob_tag_q <= issue_rob_tag_i;
            cdb_rd_q      <= issue_rd_i;
            funct3_q      <= issue_funct3_i;
            mul_a_q       <= issue_rs1_v_i;
            mul_b_q       <= issue_rs2_v_i;
            mul_type_q    <= type_d;
            if (fast_zero_d) begin
              cdb_value_q <= '0;
              cdb_valid_q <= 1'b1;
              state_q     <= RESP;
            end else begin
              mul_start_q <= 1'b1;
              state_q     <= BUSY;
            end
          end
        end
        BUSY: begin
          // The multiplier cannot be aborted; a flush only marks the result for discard.
          if (flush_i) squash_q <= 1'b1;
          if (mul_done_i) begin
            mul_start_q <= 1'b0;
            if (squash_q || flush_i) begin
              state_q <= DRAIN;
            end else begin
              cdb_value_q <= (funct3_q == 3'b000) ? mul_p_i[XLEN-1:0] : mul_p_i[2*XLEN-1:XLEN];
              cdb_valid_q <= 1'b1;
              state_q     <= RESP;
            end
          end
        end
        DRAIN: begin
          squash_q <= 1'b0;
          state_q  <= IDLE;
        end
        RESP: begin
          if (flush_i || cdb_ready_i) begin
            cdb_valid_q <= 1'b0;
            squash_q    <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign issue_ready_o = (state_q == IDLE);
  assign mul_start_o   = mul_start_q;
  assign mul_type_o    = mul_type_q;
  assign mul_a_o       = mul_a_q;
  assign mul_b_o       = mul_b_q;
  assign cdb_valid_o   = cdb_valid_q;
  assign cdb_rob_tag_o = cdb_rob_tag_q;
  assign cdb_rd_o      = cdb_rd_q;
  assign cdb_value_o   = cdb_value_q;

endmodule

// File: tb/tb_mul_fu_ctrl.sv
// Bench for mul_fu_ctrl: behavioural start/done multiplier plus a scoreboard of
// RV32M reference results pushed at issue and popped on CDB handshakes.
module tb_mul_fu_ctrl;
  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        issue_valid;
  logic        issue_ready;
  logic [2:0]  issue_funct3;
  logic [31:0] issue_rs1_v;
  logic [31:0] issue_rs2_v;
  logic [4:0]  issue_rob_tag;
  logic [4:0]  issue_rd;
  logic        mul_start;
  logic [1:0]  mul_type;
  logic [31:0] mul_a;
  logic [31:0] mul_b;
  logic [63:0] mul_p;
  logic        mul_done;
  logic        cdb_valid;
  logic        cdb_ready;
  logic [4:0]  cdb_rob_tag;
  logic [4:0]  cdb_rd;
  logic [31:0] cdb_value;

  int n_checks = 0;
  int n_fail   = 0;
  int viol     = 0;

  typedef struct packed {
    logic [31:0] value;
    logic [4:0]  tag;
    logic [4:0]  rd;
  } exp_t;
  exp_t sb_q[$];

  mul_fu_ctrl #(.ROB_IDX_W(5), .XLEN(32)) dut (
    .clk(clk), .rst(rst), .flush_i(flush),
    .issue_valid_i(issue_valid), .issue_ready_o(issue_ready),
    .issue_funct3_i(issue_funct3), .issue_rs1_v_i(issue_rs1_v), .issue_rs2_v_i(issue_rs2_v),
    .issue_rob_tag_i(issue_rob_tag), .issue_rd_i(issue_rd),
    .mul_start_o(mul_start), .mul_type_o(mul_type), .mul_a_o(mul_a), .mul_b_o(mul_b),
    .mul_p_i(mul_p), .mul_done_i(mul_done),
    .cdb_valid_o(cdb_valid), .cdb_ready_i(cdb_ready),
    .cdb_rob_tag_o(cdb_rob_tag), .cdb_rd_o(cdb_rd), .cdb_value_o(cdb_value)
  );

  always #5 clk = ~clk;

  // Behavioural multiplier: done LAT cycles after start, held while start stays high.
  int          mcnt;
  logic        mdone_q;
  logic [63:0] prod;
  always @(posedge clk) begin
    if (rst || !mul_start) begin
      mcnt    <= 0;
      mdone_q <= 1'b0;
    end else if (!mdone_q) begin
      if (mcnt == LAT - 1) mdone_q <= 1'b1;
      else mcnt <= mcnt + 1;
    end
  end
  always_comb begin
    prod = 64'h0;
    case (mul_type)
      2'b01:   prod = {{32{mul_a[31]}}, mul_a} * {{32{mul_b[31]}}, mul_b};
      2'b10:   prod = {{32{mul_a[31]}}, mul_a} * {32'h0, mul_b};
      default: prod = {32'h0, mul_a} * {32'h0, mul_b};
    endcase
  end
  assign mul_done = mdone_q & mul_start;
  assign mul_p    = mul_done ? prod : 64'h0BAD_0BAD_0BAD_0BAD;

  // Start must not drop before done, and operands must hold while start is high.
  logic        p_start, p_done;
  logic [31:0] p_a, p_b;
  logic [1:0]  p_type;
  always @(negedge clk) begin
    if (rst) begin
      p_start = 1'b0;
      p_done  = 1'b0;
    end else begin
      if (p_start && !mul_start && !p_done) viol++;
      if (p_start && mul_start && (mul_a !== p_a || mul_b !== p_b || mul_type !== p_type)) viol++;
      p_start = mul_start;
      p_done  = mul_done;
      p_a     = mul_a;
      p_b     = mul_b;
      p_type  = mul_type;
    end
  end

  function automatic logic [31:0] ref_res(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0] p;
    logic [31:0] r;
    p = 64'h0;
    r = 32'h0;
    case (f3)
      3'b000: begin p = {32'h0, a} * {32'h0, b};               r = p[31:0];  end
      3'b001: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b};   r = p[63:32]; end
      3'b010: begin p = {{32{a[31]}}, a} * {32'h0, b};         r = p[63:32]; end
      3'b011: begin p = {32'h0, a} * {32'h0, b};               r = p[63:32]; end
      default: r = 32'h0;
    endcase
    return r;
  endfunction

  function automatic logic [1:0] ref_type(input logic [2:0] f3);
    if (f3 == 3'b001) return 2'b01;
    if (f3 == 3'b010) return 2'b10;
    return 2'b00;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] tag, input logic [4:0] rd, input bit keep);
    exp_t e;
    issue_funct3  = f3;
    issue_rs1_v   = a;
    issue_rs2_v   = b;
    issue_rob_tag = tag;
    issue_rd      = rd;
    issue_valid   = 1'b1;
    if (keep) begin
      e.value = ref_res(f3, a, b);
      e.tag   = tag;
      e.rd    = rd;
      sb_q.push_back(e);
    end
    step();
    issue_valid = 1'b0;
  endtask

  task automatic wait_cdb(input int max, output int n);
    n = 0;
    while (cdb_valid !== 1'b1 && n < max) begin
      step();
      n++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    n_checks++;
    if ({mul_start, mul_type, mul_a, mul_b} !== 67'h0) begin
      n_fail++; $display("FAIL reset_mul: got %h expected 0", {mul_start, mul_type, mul_a, mul_b});
    end
    n_checks++;
    if ({cdb_valid, cdb_rob_tag, cdb_rd, cdb_value} !== 43'h0) begin
      n_fail++; $display("FAIL reset_cdb: got %h expected 0", {cdb_valid, cdb_rob_tag, cdb_rd, cdb_value});
    end
    n_checks++;
    if (issue_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready: got %b expected 1", issue_ready);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_mul();
    int n;
    exp_t e;
    do_issue(3'b000, 32'd7, 32'd6, 5'd3, 5'd10, 1'b1);
    n_checks++;
    if (mul_start !== 1'b1 || mul_type !== 2'b00) begin
      n_fail++; $display("FAIL mul_start_type: got start=%b type=%b expected start=1 type=00", mul_start, mul_type);
    end
    n_checks++;
    if (issue_ready !== 1'b0) begin
      n_fail++; $display("FAIL mul_busy_ready: got %b expected 0", issue_ready);
    end
    wait_cdb(20, n);
    n_checks++;
    if (n !== LAT + 1) begin
      n_fail++; $display("FAIL mul_latency: got %0d expected %0d", n, LAT + 1);
    end
    n_checks++;
    if (mul_start !== 1'b0) begin
      n_fail++; $display("FAIL mul_start_resp: got %b expected 0", mul_start);
    end
    e = sb_q.pop_front();
    n_checks++;
    if (cdb_value !== e.value || cdb_value !== 32'd42 || cdb_rob_tag !== e.tag || cdb_rd !== e.rd) begin
      n_fail++; $display("FAIL mul_result: got v=%h t=%0d rd=%0d expected v=%h t=%0d rd=%0d",
                         cdb_value, cdb_rob_tag, cdb_rd, e.value, e.tag, e.rd);
    end
    step();
    n_checks++;
    if (cdb_valid !== 1'b0 || issue_ready !== 1'b1) begin
      n_fail++; $display("FAIL mul_after_hs: got valid=%b ready=%b expected valid=0 ready=1", cdb_valid, issue_ready);
    end
  endtask

  task automatic test_high_variants();
    logic [2:0]  f3s [4] = '{3'b001, 3'b011, 3'b010, 3'b100};
    logic [31:0] as  [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd5};
    logic [31:0] bs  [4] = '{32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd5};
    logic [31:0] vs  [4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0};
    int n;
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      do_issue(f3s[i], as[i], bs[i], 5'(i + 8), 5'(i + 1), 1'b1);
      n_checks++;
      if (f3s[i][2] ? (mul_start !== 1'b0) : (mul_start !== 1'b1 || mul_type !== ref_type(f3s[i]))) begin
        n_fail++; $display("FAIL hi_type[%0d]: got start=%b type=%b expected type=%b", i, mul_start, mul_type, ref_type(f3s[i]));
      end
      wait_cdb(20, n);
      n_checks++;
      if (n >= 20) begin
        n_fail++; $display("FAIL hi_timeout[%0d]: got no cdb_valid expected one", i);
      end
      e = sb_q.pop_front();
      n_checks++;
      if (cdb_value !== vs[i] || cdb_value !== e.value || cdb_rob_tag !== e.tag) begin
        n_fail++; $display("FAIL hi_value[%0d]: got %h tag %0d expected %h tag %0d", i, cdb_value, cdb_rob_tag, vs[i], e.tag);
      end
      step();
    end
  endtask

  task automatic test_zero();
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      do_issue(3'b000, i == 0 ? 32'h0 : 32'h55, i == 0 ? 32'h1234 : 32'h0, 5'd20, 5'd7, 1'b1);
      e = sb_q.pop_front();
      n_checks++;
      if (cdb_valid !== 1'b1 || cdb_value !== e.value || cdb_rob_tag !== e.tag || mul_start !== 1'b0) begin
        n_fail++; $display("FAIL zero_path[%0d]: got valid=%b v=%h start=%b expected valid=1 v=%h start=0",
                           i, cdb_valid, cdb_value, mul_start, e.value);
      end
      step();
      n_checks++;
      if (mul_start !== 1'b0 || cdb_valid !== 1'b0) begin
        n_fail++; $display("FAIL zero_done[%0d]: got start=%b valid=%b expected 0 0", i, mul_start, cdb_valid);
      end
    end
  endtask

  task automatic test_flush_busy();
    int n;
    bit saw_valid;
    exp_t e;
    saw_valid = 1'b0;
    do_issue(3'b011, 32'h1234_5678, 32'h9ABC_DEF0, 5'd11, 5'd12, 1'b0);
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    n = 0;
    while (mul_start === 1'b1 && n < 20) begin
      if (cdb_valid === 1'b1) saw_valid = 1'b1;
      step();
      n++;
    end
    n_checks++;
    if (n >= 20 || issue_ready !== 1'b0 || cdb_valid !== 1'b0) begin
      n_fail++; $display("FAIL flush_drain: got n=%0d ready=%b valid=%b expected ready=0 valid=0", n, issue_ready, cdb_valid);
    end
    step();
    n_checks++;
    if (issue_ready !== 1'b1 || cdb_valid !== 1'b0 || saw_valid) begin
      n_fail++; $display("FAIL flush_idle: got ready=%b valid=%b saw=%b expected ready=1 valid=0 saw=0",
                         issue_ready, cdb_valid, saw_valid);
    end
    do_issue(3'b000, 32'd3, 32'd3, 5'd13, 5'd14, 1'b1);
    wait_cdb(20, n);
    e = sb_q.pop_front();
    n_checks++;
    if (cdb_valid !== 1'b1 || cdb_value !== 32'd9 || cdb_value !== e.value || cdb_rob_tag !== e.tag) begin
      n_fail++; $display("FAIL flush_next: got valid=%b v=%h tag=%0d expected valid=1 v=%h tag=%0d",
                         cdb_valid, cdb_value, cdb_rob_tag, e.value, e.tag);
    end
    step();
  endtask

  task automatic test_flush_resp_idle();
    int n;
    cdb_ready = 1'b0;
    do_issue(3'b000, 32'd2, 32'd3, 5'd15, 5'd16, 1'b0);
    wait_cdb(20, n);
    flush     = 1'b1;
    cdb_ready = 1'b1;
    step();
    flush = 1'b0;
    n_checks++;
    if (n >= 20 || cdb_valid !== 1'b0 || issue_ready !== 1'b1) begin
      n_fail++; $display("FAIL flush_resp: got n=%0d valid=%b ready=%b expected valid=0 ready=1", n, cdb_valid, issue_ready);
    end
    flush         = 1'b1;
    issue_valid   = 1'b1;
    issue_funct3  = 3'b000;
    issue_rs1_v   = 32'h0;
    issue_rs2_v   = 32'd5;
    issue_rob_tag = 5'd17;
    step();
    flush       = 1'b0;
    issue_valid = 1'b0;
    n_checks++;
    if (cdb_valid !== 1'b0 || mul_start !== 1'b0 || issue_ready !== 1'b1) begin
      n_fail++; $display("FAIL flush_idle_issue: got valid=%b start=%b ready=%b expected 0 0 1", cdb_valid, mul_start, issue_ready);
    end
  endtask

  task automatic test_backpressure();
    int n;
    exp_t e;
    cdb_ready = 1'b0;
    do_issue(3'b000, 32'd2, 32'd2, 5'd9, 5'd18, 1'b1);
    wait_cdb(20, n);
    e = sb_q.pop_front();
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (cdb_valid !== 1'b1 || cdb_value !== 32'd4 || cdb_value !== e.value || cdb_rob_tag !== e.tag || issue_ready !== 1'b0) begin
        n_fail++; $display("FAIL bp_hold[%0d]: got valid=%b v=%h tag=%0d ready=%b expected valid=1 v=%h tag=%0d ready=0",
                           k, cdb_valid, cdb_value, cdb_rob_tag, issue_ready, e.value, e.tag);
      end
      step();
    end
    cdb_ready = 1'b1;
    step();
    n_checks++;
    if (cdb_valid !== 1'b0 || issue_ready !== 1'b1) begin
      n_fail++; $display("FAIL bp_release: got valid=%b ready=%b expected valid=0 ready=1", cdb_valid, issue_ready);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    exp_t e;
    logic [2:0]  f3;
    logic [31:0] a, b;
    for (int i = 0; i < 24; i++) begin
      f3 = 3'($urandom_range(0, 4));
      a  = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
      b  = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
      n_checks++;
      if (issue_ready !== 1'b1) begin
        n_fail++; $display("FAIL b2b_ready[%0d]: got %b expected 1", i, issue_ready);
      end
      do_issue(f3, a, b, 5'(i), 5'($urandom_range(0, 31)), 1'b1);
      wait_cdb(20, n);
      e = sb_q.pop_front();
      n_checks++;
      if (n >= 20 || cdb_value !== e.value || cdb_rob_tag !== e.tag || cdb_rd !== e.rd) begin
        n_fail++; $display("FAIL b2b_result[%0d]: got v=%h t=%0d rd=%0d expected v=%h t=%0d rd=%0d (f3=%b a=%h b=%h)",
                           i, cdb_value, cdb_rob_tag, cdb_rd, e.value, e.tag, e.rd, f3, a, b);
      end
      step();
    end
  endtask

  task automatic test_reset_mid();
    do_issue(3'b000, 32'd5, 32'd5, 5'd21, 5'd22, 1'b0);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_checks++;
    if (mul_start !== 1'b0 || cdb_valid !== 1'b0 || issue_ready !== 1'b1 || mul_a !== 32'h0 || cdb_rob_tag !== 5'h0) begin
      n_fail++; $display("FAIL reset_mid: got start=%b valid=%b ready=%b a=%h tag=%0d expected 0 0 1 0 0",
                         mul_start, cdb_valid, issue_ready, mul_a, cdb_rob_tag);
    end
    step();
  endtask

  task automatic test_protocol();
    n_checks++;
    if (viol !== 0) begin
      n_fail++; $display("FAIL mul_handshake: got %0d violations expected 0", viol);
    end
    n_checks++;
    if (sb_q.size() !== 0) begin
      n_fail++; $display("FAIL scoreboard_empty: got %0d entries expected 0", sb_q.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst           = 1'b1;
    flush         = 1'b0;
    issue_valid   = 1'b0;
    issue_funct3  = 3'b000;
    issue_rs1_v   = 32'h0;
    issue_rs2_v   = 32'h0;
    issue_rob_tag = 5'h0;
    issue_rd      = 5'h0;
    cdb_ready     = 1'b1;
    test_reset();
    test_mul();
    test_high_variants();
    test_zero();
    test_flush_busy();
    test_flush_resp_idle();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_protocol();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
